// File: rtl/load_store_unit_pkg.sv
// Shared encodings and decode helpers for the RV32I load/store unit.
// The misalignment helper is only consulted when LSU_MISALIGN_TRAP_EN is defined.
package load_store_unit_pkg;

   localparam int WORD_LEN  = 32;
   localparam int ADDR_SIZE = 32;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_BUSY = 2'b01,
      LSU_RESP = 2'b10
   } lsu_state_e;

   // Unsigned variants exist only for loads.
   function automatic logic lsu_f3_ok(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         LSU_F3_B, LSU_F3_H, LSU_F3_W: ok = 1'b1;
         LSU_F3_BU, LSU_F3_HU:         ok = ~we;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3)
         LSU_F3_H, LSU_F3_HU: mis = lo[0];
         LSU_F3_W:            mis = (lo != 2'b00);
         default:             mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side req/ack bundle of the load/store unit.
interface load_store_unit_if;
   import load_store_unit_pkg::*;

   logic                 req_valid;
   logic                 req_we;
   logic [2:0]           req_funct3;
   logic [ADDR_SIZE-1:0] req_addr;
   logic [WORD_LEN-1:0]  req_wdata;
   logic                 stall;
   logic                 rsp_valid;
   logic [WORD_LEN-1:0]  rsp_rdata;
   logic                 rsp_err;
   logic                 rsp_misalign;
   logic                 mem_req;
   logic                 mem_we;
   logic [3:0]           mem_be;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WORD_LEN-1:0]  mem_wdata;
   logic                 mem_ack;
   logic [WORD_LEN-1:0]  mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      output stall, rsp_valid, rsp_rdata, rsp_err, rsp_misalign,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      input  stall, rsp_valid, rsp_rdata, rsp_err, rsp_misalign,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane steering for stores and select/extend for loads.
module load_store_unit_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic [1:0]          addr_lo,
   input  logic [WORD_LEN-1:0] wdata,
   input  logic [WORD_LEN-1:0] rdata,
   output logic [3:0]          be,
   output logic [WORD_LEN-1:0] wdata_lanes,
   output logic [WORD_LEN-1:0] rdata_ext
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Store steering is keyed on access size (funct3[1:0]).
   always_comb begin
      be          = 4'b1111;
      wdata_lanes = wdata;
      case (funct3[1:0])
         2'b00: begin
            be          = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
         end
         2'b01: begin
            be          = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
         end
         default: begin
            be          = 4'b1111;
            wdata_lanes = wdata;
         end
      endcase
   end

   // Load lane select followed by sign or zero extension.
   always_comb begin
      byte_s    = 8'h00;
      half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      rdata_ext = 32'h0000_0000;
      case (addr_lo)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      case (funct3)
         LSU_F3_B:  rdata_ext = {{24{byte_s[7]}}, byte_s};
         LSU_F3_H:  rdata_ext = {{16{half_s[15]}}, half_s};
         LSU_F3_W:  rdata_ext = rdata;
         LSU_F3_BU: rdata_ext = {24'h00_0000, byte_s};
         LSU_F3_HU: rdata_ext = {16'h0000, half_s};
         default:   rdata_ext = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// One-access-at-a-time load/store unit: IDLE -> BUSY -> RESP FSM with BUSY timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of truncating.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);

   lsu_state_e          state_r, state_s;
   logic [2:0]          acc_f3_r;
   logic [1:0]          acc_lo_r;
   logic [7:0]          cnt_r;
   logic                mem_req_r, mem_we_r;
   logic [3:0]          mem_be_r;
   logic [ADDR_SIZE-1:0] mem_addr_r;
   logic [WORD_LEN-1:0] mem_wdata_r, rsp_rdata_r;
   logic                rsp_valid_r, rsp_err_r, rsp_misalign_r;

   logic                idle_s, bad_f3_s, misalign_s, timeout_s;
   logic [2:0]          sel_f3_s;
   logic [1:0]          sel_lo_s;
   logic [3:0]          be_s;
   logic [WORD_LEN-1:0] wdata_s, rdata_s;

   assign idle_s   = (state_r == LSU_IDLE);
   assign sel_f3_s = idle_s ? bus.req_funct3 : acc_f3_r;
   assign sel_lo_s = idle_s ? bus.req_addr[1:0] : acc_lo_r;
   assign bad_f3_s = ~lsu_f3_ok(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_s = ~bad_f3_s & lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif
   assign timeout_s = TO_EN && (cnt_r == TO_LAST) && !bus.mem_ack;

   load_store_unit_align u_align (
      .funct3      (sel_f3_s),
      .addr_lo     (sel_lo_s),
      .wdata       (bus.req_wdata),
      .rdata       (bus.mem_rdata),
      .be          (be_s),
      .wdata_lanes (wdata_s),
      .rdata_ext   (rdata_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= LSU_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; an ack beats a same-cycle timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         LSU_IDLE: begin
            if (bus.req_valid) begin
               state_s = (bad_f3_s || misalign_s) ? LSU_RESP : LSU_BUSY;
            end else begin
               state_s = LSU_IDLE;
            end
         end
         LSU_BUSY: begin
            if (bus.mem_ack || timeout_s) begin
               state_s = LSU_RESP;
            end else begin
               state_s = LSU_BUSY;
            end
         end
         LSU_RESP: state_s = LSU_IDLE;
         default:  state_s = LSU_IDLE;
      endcase
   end

   // Access latch, memory-side outputs, response registers and timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_f3_r       <= 3'b000;
         acc_lo_r       <= 2'b00;
         cnt_r          <= 8'h00;
         mem_req_r      <= 1'b0;
         mem_we_r       <= 1'b0;
         mem_be_r       <= 4'b0000;
         mem_addr_r     <= 32'h0000_0000;
         mem_wdata_r    <= 32'h0000_0000;
         rsp_valid_r    <= 1'b0;
         rsp_rdata_r    <= 32'h0000_0000;
         rsp_err_r      <= 1'b0;
         rsp_misalign_r <= 1'b0;
      end else begin
         case (state_r)
            LSU_IDLE: begin
               if (bus.req_valid) begin
                  acc_f3_r <= bus.req_funct3;
                  acc_lo_r <= bus.req_addr[1:0];
                  cnt_r    <= 8'h00;
                  if (bad_f3_s || misalign_s) begin
                     rsp_valid_r    <= 1'b1;
                     rsp_err_r      <= bad_f3_s;
                     rsp_misalign_r <= misalign_s;
                     rsp_rdata_r    <= 32'h0000_0000;
                  end else begin
                     mem_req_r   <= 1'b1;
                     mem_we_r    <= bus.req_we;
                     mem_be_r    <= be_s;
                     mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
                     mem_wdata_r <= bus.req_we ? wdata_s : 32'h0000_0000;
                  end
               end
            end
            LSU_BUSY: begin
               if (bus.mem_ack) begin
                  mem_req_r   <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b0;
                  rsp_rdata_r <= mem_we_r ? 32'h0000_0000 : rdata_s;
               end else if (timeout_s) begin
                  mem_req_r   <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b1;
                  rsp_rdata_r <= 32'h0000_0000;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            LSU_RESP: begin
               rsp_valid_r    <= 1'b0;
               rsp_err_r      <= 1'b0;
               rsp_misalign_r <= 1'b0;
               rsp_rdata_r    <= 32'h0000_0000;
               mem_we_r       <= 1'b0;
               mem_be_r       <= 4'b0000;
               mem_addr_r     <= 32'h0000_0000;
               mem_wdata_r    <= 32'h0000_0000;
            end
            default: begin
               mem_req_r   <= 1'b0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stall        = (idle_s && bus.req_valid) || (state_r == LSU_BUSY);
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_rdata    = rsp_rdata_r;
   assign bus.rsp_err      = rsp_err_r;
   assign bus.rsp_misalign = rsp_misalign_r;
   assign bus.mem_req      = mem_req_r;
   assign bus.mem_we       = mem_we_r;
   assign bus.mem_be       = mem_be_r;
   assign bus.mem_addr     = mem_addr_r;
   assign bus.mem_wdata    = mem_wdata_r;

endmodule
